// File: rtl/spi_master_pkg.sv
// Shared types for the SPI mode-0 initiator: FSM state encoding and counter sizing.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GUARD = 3'd4
  } spiStateT;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cntWidth(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/spi_master_sclk_gen.sv
// Half-period timer: pulses tick for one cycle every CLKDIV cycles while enabled.
module spi_master_sclk_gen
  import spi_master_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  output logic tick
);

  localparam int HW = cntWidth(CLKDIV);
  localparam logic [HW-1:0] LAST = HW'(CLKDIV - 1);

  logic [HW-1:0] halfCnt;

  // Count clk cycles within the current sclk half-period; hold at zero while disabled.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      halfCnt <= {HW{1'b0}};
    end else if (!enable) begin
      halfCnt <= {HW{1'b0}};
    end else if (halfCnt == LAST) begin
      halfCnt <= {HW{1'b0}};
    end else begin
      halfCnt <= halfCnt + HW'(1);
    end
  end

  assign tick = enable && (halfCnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one start strobe shifts WIDTH bits out on mosi and in from miso, MSB first.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData,
  output logic             sclk,
  output logic             csN,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_FALL = BW'(WIDTH - 1);

  spiStateT         state;
  spiStateT         stateNext;
  logic             tick;
  logic [WIDTH-1:0] txShift;
  logic [WIDTH-1:0] txShiftNext;
  logic [WIDTH-1:0] rxShift;
  logic [WIDTH-1:0] rxShiftNext;
  logic [WIDTH-1:0] rxDataNext;
  logic [BW-1:0]    fallCnt;
  logic [BW-1:0]    fallCntNext;
  logic             sclkNext;
  logic             csNNext;
  logic             mosiNext;
  logic             busyNext;
  logic             doneNext;

  spi_master_sclk_gen #(
    .CLKDIV(CLKDIV)
  ) uSclkGen (
    .clk   (clk),
    .resetN(resetN),
    .enable(state != IDLE),
    .tick  (tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; every phase after IDLE advances only on a half-period tick.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = LEAD;
        end else begin
          stateNext = IDLE;
        end
      end
      LEAD: begin
        if (tick) begin
          stateNext = SHIFT;
        end else begin
          stateNext = LEAD;
        end
      end
      SHIFT: begin
        if (tick && sclk && (fallCnt == LAST_FALL)) begin
          stateNext = TRAIL;
        end else begin
          stateNext = SHIFT;
        end
      end
      TRAIL: begin
        if (tick) begin
          stateNext = GUARD;
        end else begin
          stateNext = TRAIL;
        end
      end
      GUARD: begin
        if (tick) begin
          stateNext = IDLE;
        end else begin
          stateNext = GUARD;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Next values of shifters, counters and output registers.
  always_comb begin
    txShiftNext = txShift;
    rxShiftNext = rxShift;
    rxDataNext  = rxData;
    fallCntNext = fallCnt;
    sclkNext    = sclk;
    csNNext     = csN;
    mosiNext    = mosi;
    busyNext    = busy;
    doneNext    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          txShiftNext = txData;
          rxShiftNext = {WIDTH{1'b0}};
          fallCntNext = {BW{1'b0}};
          csNNext     = 1'b0;
          busyNext    = 1'b1;
          mosiNext    = txData[WIDTH-1];
        end else begin
          csNNext  = 1'b1;
          busyNext = 1'b0;
          sclkNext = 1'b0;
        end
      end
      LEAD: begin
        if (tick) begin
          sclkNext    = 1'b1;
          rxShiftNext = {rxShift[WIDTH-2:0], miso};
        end else begin
          sclkNext = 1'b0;
        end
      end
      SHIFT: begin
        if (tick && sclk) begin
          sclkNext    = 1'b0;
          fallCntNext = fallCnt + BW'(1);
          // The last falling edge leaves mosi alone; the line idles low in TRAIL.
          if (fallCnt != LAST_FALL) begin
            txShiftNext = {txShift[WIDTH-2:0], txShift[WIDTH-1]};
            mosiNext    = txShift[WIDTH-2];
          end else begin
            mosiNext = mosi;
          end
        end else if (tick) begin
          sclkNext    = 1'b1;
          rxShiftNext = {rxShift[WIDTH-2:0], miso};
        end else begin
          sclkNext = sclk;
        end
      end
      TRAIL: begin
        if (tick) begin
          csNNext  = 1'b1;
          mosiNext = 1'b0;
        end else begin
          csNNext = 1'b0;
        end
      end
      GUARD: begin
        if (tick) begin
          rxDataNext = rxShift;
          doneNext   = 1'b1;
          busyNext   = 1'b0;
        end else begin
          busyNext = 1'b1;
        end
      end
      default: begin
        sclkNext = 1'b0;
        csNNext  = 1'b1;
        mosiNext = 1'b0;
        busyNext = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset forces csN high immediately and discards any partial word.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      txShift <= {WIDTH{1'b0}};
      rxShift <= {WIDTH{1'b0}};
      rxData  <= {WIDTH{1'b0}};
      fallCnt <= {BW{1'b0}};
      sclk    <= 1'b0;
      csN     <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      txShift <= txShiftNext;
      rxShift <= rxShiftNext;
      rxData  <= rxDataNext;
      fallCnt <= fallCntNext;
      sclk    <= sclkNext;
      csN     <= csNNext;
      mosi    <= mosiNext;
      busy    <= busyNext;
      done    <= doneNext;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus queues expected words and done times, monitors check on done.
module tb_spi_master;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         doneCyc;
  } expT;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       busy, done, sclk, csN, mosi, miso;
  logic [7:0] rxData;
  logic       loopback = 1'b1;
  logic       pMiso = 1'b0;
  logic [7:0] pWord = 8'h00;
  logic [7:0] pShift = 8'h00;
  assign miso = loopback ? mosi : pMiso;

  logic       start1 = 1'b0;
  logic [7:0] txData1 = 8'h00;
  logic       busy1, done1, sclk1, csN1, mosi1;
  logic [7:0] rxData1;

  spi_master #(.WIDTH(8), .CLKDIV(4)) dut (
    .clk(clk), .resetN(resetN), .start(start), .txData(txData), .busy(busy), .done(done),
    .rxData(rxData), .sclk(sclk), .csN(csN), .mosi(mosi), .miso(miso)
  );

  spi_master #(.WIDTH(8), .CLKDIV(1)) dut1 (
    .clk(clk), .resetN(resetN), .start(start1), .txData(txData1), .busy(busy1), .done(done1),
    .rxData(rxData1), .sclk(sclk1), .csN(csN1), .mosi(mosi1), .miso(mosi1)
  );

  int  cyc = 0;
  int  total = 0;
  int  passed = 0;
  expT sb[$];
  expT sb1[$];
  int  doneCount = 0;
  int  riseCnt = 0, riseCnt1 = 0;
  logic [7:0] mosiBits = 8'h00, mosiBits1 = 8'h00;
  logic prevSclk = 1'b0, prevCs = 1'b1, prevDone = 1'b0;
  logic prevSclk1 = 1'b0, prevCs1 = 1'b1;
  int  csRiseCyc = 0, csHighLen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and peripheral model for the CLKDIV=4 instance.
  always @(negedge clk) begin
    expT e;
    if (!csN && prevCs) begin
      riseCnt  = 0;
      mosiBits = 8'h00;
      pShift   = pWord;
      pMiso    = pShift[7];
      csHighLen = cyc - csRiseCyc;
    end
    if (csN && !prevCs) csRiseCyc = cyc;
    if (sclk && !prevSclk && !csN) begin
      riseCnt++;
      mosiBits = {mosiBits[6:0], mosi};
    end
    if (!sclk && prevSclk && !csN) begin
      pShift = {pShift[6:0], 1'b0};
      pMiso  = pShift[7];
    end
    if (done) begin
      doneCount++;
      check("donePulseWidth", 32'(prevDone), 32'd0);
      if (sb.size() == 0) begin
        check("unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rxData", 32'(rxData), 32'(e.rx));
        check("mosiBits", 32'(mosiBits), 32'(e.tx));
        check("sclkRises", 32'(riseCnt), 32'd8);
        check("doneCycle", 32'(cyc), 32'(e.doneCyc));
      end
    end
    prevSclk = sclk;
    prevCs   = csN;
    prevDone = done;
  end

  // Monitor for the CLKDIV=1 loopback instance.
  always @(negedge clk) begin
    expT e;
    if (!csN1 && prevCs1) begin
      riseCnt1  = 0;
      mosiBits1 = 8'h00;
    end
    if (sclk1 && !prevSclk1 && !csN1) begin
      riseCnt1++;
      mosiBits1 = {mosiBits1[6:0], mosi1};
    end
    if (done1) begin
      if (sb1.size() == 0) begin
        check("unexpectedDone1", 32'd1, 32'd0);
      end else begin
        e = sb1.pop_front();
        check("rxData1", 32'(rxData1), 32'(e.rx));
        check("mosiBits1", 32'(mosiBits1), 32'(e.tx));
        check("sclkRises1", 32'(riseCnt1), 32'd8);
        check("doneCycle1", 32'(cyc), 32'(e.doneCyc));
      end
    end
    prevSclk1 = sclk1;
    prevCs1   = csN1;
  end

  task automatic startXfer(input logic [7:0] tx, input logic [7:0] rx, input bit hold, output int e0);
    @(negedge clk);
    txData = tx;
    start  = 1'b1;
    e0     = cyc + 1;
    sb.push_back('{rx: rx, tx: tx, doneCyc: e0 + 72});
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("waitIdleTimeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int e0;
    int dcBefore;
    int n;

    repeat (3) @(negedge clk);
    check("rstCsN", 32'(csN), 32'd1);
    check("rstSclk", 32'(sclk), 32'd0);
    check("rstMosi", 32'(mosi), 32'd0);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstDone", 32'(done), 32'd0);
    check("rstRxData", 32'(rxData), 32'd0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback of an asymmetric pattern.
    startXfer(8'b10001010, 8'b10001010, 1'b0, e0);
    check("busyAfterAccept", 32'(busy), 32'd1);
    check("csNAfterAccept", 32'(csN), 32'd0);
    waitIdle(200);

    // Peripheral returns 0x5A while we send 0xFF.
    loopback = 1'b0;
    pWord    = 8'h5A;
    startXfer(8'hFF, 8'h5A, 1'b0, e0);
    waitIdle(200);
    loopback = 1'b1;

    // A second start during busy must be ignored.
    dcBefore = doneCount;
    startXfer(8'h33, 8'h33, 1'b0, e0);
    while (cyc < e0 + 19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle(200);
    repeat (90) @(negedge clk);
    check("ignoredStartDones", 32'(doneCount - dcBefore), 32'd1);

    // Reset in the middle of SHIFT.
    startXfer(8'hA5, 8'hA5, 1'b0, e0);
    while (cyc < e0 + 20) @(negedge clk);
    resetN = 1'b0;
    sb.delete();
    #1;
    check("midRstCsN", 32'(csN), 32'd1);
    check("midRstSclk", 32'(sclk), 32'd0);
    check("midRstBusy", 32'(busy), 32'd0);
    check("midRstDone", 32'(done), 32'd0);
    check("midRstRxData", 32'(rxData), 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    startXfer(8'h96, 8'h96, 1'b0, e0);
    waitIdle(200);

    // start held high: second word accepted on the edge after done.
    startXfer(8'h3C, 8'h3C, 1'b1, e0);
    repeat (10) @(negedge clk);
    txData = 8'hC3;
    sb.push_back('{rx: 8'hC3, tx: 8'hC3, doneCyc: e0 + 73 + 72});
    n = 0;
    while (cyc < e0 + 73 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("secondAcceptBusy", 32'(busy), 32'd1);
    waitIdle(200);
    check("csHighBetween", 32'(csHighLen), 32'd5);

    // CLKDIV=1 loopback.
    @(negedge clk);
    txData1 = 8'b10001010;
    start1  = 1'b1;
    e0      = cyc + 1;
    sb1.push_back('{rx: 8'b10001010, tx: 8'b10001010, doneCyc: e0 + 18});
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy1) check("waitIdle1Timeout", 32'd1, 32'd0);
    repeat (5) @(negedge clk);

    check("pendingExpected", 32'(sb.size()), 32'd0);
    check("pendingExpected1", 32'(sb1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
